mult32x32_ctrl: RTL and testbench

FSM sequencer driving the 32x32 multiplier arithmetic unit (8-bit x 16-bit partial-product datapath with a 64-bit accumulating product register).
- Accepts a start request and clears the product register.
- Steps through the eight byte/half-word partial products, generating a_sel, b_sel, shift_sel and upd_prod.
- Signals busy/done to the requester.
- Optionally skips partial products whose operand slice is zero, which shortens latency.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_step_finder.sv | 23 ++
 rtl/mult32x32_ctrl.sv | 117 +++++++++++
 tb/tb_mult32x32_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and step-mapping helpers for the 32x32 multiplier sequencer.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_STEPS = 8;
    localparam int STEP_W    = 3;
    localparam int A_SEL_W   = 2;
    localparam int SHIFT_W   = 3;

    // Byte offset of step k is 8*(a_sel + 2*b_sel), so the shifter select is that sum.
    function automatic logic [SHIFT_W-1:0] step_to_shift(input logic [STEP_W-1:0] k);
        return {1'b0, k[1:0]} + {1'b0, k[2], 1'b0};
    endfunction

endpackage

// File: rtl/mult_step_finder.sv
// Priority search: lowest index >= from_idx whose need bit is set.
import mult_pkg::*;

module mult_step_finder (
    input  logic [NUM_STEPS-1:0] need,
    input  logic [STEP_W:0]      from_idx,
    output logic [STEP_W-1:0]    idx,
    output logic                 found
);

    // Scanning downwards lets the lowest qualifying index win the last assignment.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_STEPS - 1; i >= 0; i--) begin
            if (need[i] && (4'(i) >= from_idx)) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult32x32_ctrl.sv
// Sequencer for the 8x16 partial-product datapath: clears, steps through needed
// partial products, and reports busy/done to the requester.
import mult_pkg::*;

module mult32x32_ctrl #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [1:0]  a_sel,
    output logic        b_sel,
    output logic [2:0]  shift_sel,
    output logic        upd_prod,
    output logic        clr_prod
);

    // Handshake: start is a request pulse taken only in IDLE (clr_prod echoes
    // acceptance in that same cycle); busy covers the RUN cycles; done pulses
    // once with the product valid; a and b must stay stable until done.

    state_t                state, state_n;
    logic [STEP_W-1:0]     step, step_n;
    logic [NUM_STEPS-1:0]  need_q, need_n, need_now;

    logic [STEP_W-1:0]     load_idx, adv_idx;
    logic                  load_found, adv_found;

    always_comb begin
        need_now = '0;
        for (int k = 0; k < NUM_STEPS; k++) begin
            if (!SKIP_ZERO)
                need_now[k] = 1'b1;
            else
                need_now[k] = (a[8*(k%4) +: 8] != 8'd0) && (b[16*(k/4) +: 16] != 16'd0);
        end
    end

    mult_step_finder u_load_finder (
        .need     (need_now),
        .from_idx (4'd0),
        .idx      (load_idx),
        .found    (load_found)
    );

    mult_step_finder u_adv_finder (
        .need     (need_q),
        .from_idx ({1'b0, step} + 4'd1),
        .idx      (adv_idx),
        .found    (adv_found)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            step   <= '0;
            need_q <= '0;
        end else begin
            state  <= state_n;
            step   <= step_n;
            need_q <= need_n;
        end
    end

    always_comb begin
        state_n   = state;
        step_n    = step;
        need_n    = need_q;
        busy      = 1'b0;
        done      = 1'b0;
        a_sel     = '0;
        b_sel     = 1'b0;
        shift_sel = '0;
        upd_prod  = 1'b0;
        clr_prod  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !reset) begin
                    clr_prod = 1'b1;
                    need_n   = need_now;
                    if (load_found) begin
                        step_n  = load_idx;
                        state_n = RUN;
                    end else begin
                        step_n  = '0;
                        state_n = DONE;
                    end
                end
            end
            RUN: begin
                busy      = 1'b1;
                upd_prod  = 1'b1;
                a_sel     = step[1:0];
                b_sel     = step[2];
                shift_sel = step_to_shift(step);
                if (adv_found)
                    step_n = adv_idx;
                else
                    state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                step_n  = '0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                step_n  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mult32x32_ctrl.sv
// Bench for mult32x32_ctrl: one instance per SKIP_ZERO setting, a behavioural
// product register fed by the sequencer outputs, and a cycle-by-cycle reference.
import mult_pkg::*;

module tb_mult32x32_ctrl;

    logic        clk;
    logic        reset;
    logic        start_v     [2];
    logic [31:0] a_v         [2];
    logic [31:0] b_v         [2];
    logic        busy_v      [2];
    logic        done_v      [2];
    logic [1:0]  a_sel_v     [2];
    logic        b_sel_v     [2];
    logic [2:0]  shift_sel_v [2];
    logic        upd_v       [2];
    logic        clr_v       [2];
    logic [63:0] prod        [2];

    int errors = 0;
    int checks = 0;
    logic [2:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mult32x32_ctrl #(.SKIP_ZERO(1'b0)) u0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .a_sel(a_sel_v[0]), .b_sel(b_sel_v[0]),
        .shift_sel(shift_sel_v[0]), .upd_prod(upd_v[0]), .clr_prod(clr_v[0])
    );

    mult32x32_ctrl #(.SKIP_ZERO(1'b1)) u1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .a_sel(a_sel_v[1]), .b_sel(b_sel_v[1]),
        .shift_sel(shift_sel_v[1]), .upd_prod(upd_v[1]), .clr_prod(clr_v[1])
    );

    // Behavioural arith unit: 8x16 partial product shifted by 8*shift_sel bits.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (clr_v[u])
                prod[u] <= 64'd0;
            else if (upd_v[u])
                prod[u] <= prod[u] + ((64'(a_v[u][8*a_sel_v[u] +: 8]) *
                                       64'(b_v[u][16*b_sel_v[u] +: 16])) << (8*shift_sel_v[u]));
        end
    end

    // ---------------- checking helpers ----------------
    function automatic logic [9:0] obs(input int u);
        return {done_v[u], busy_v[u], upd_v[u], clr_v[u], a_sel_v[u], b_sel_v[u], shift_sel_v[u]};
    endfunction

    function automatic logic [9:0] exp_run(input int k);
        logic [1:0] as;
        logic       bs;
        logic [2:0] sh;
        as = 2'(k % 4);
        bs = 1'(k / 4);
        sh = 3'((k % 4) + 2 * (k / 4));
        return {1'b0, 1'b1, 1'b1, 1'b0, as, bs, sh};
    endfunction

    localparam logic [9:0] EXP_IDLE  = 10'b0000_00_0_000;
    localparam logic [9:0] EXP_CLR   = 10'b0001_00_0_000;
    localparam logic [9:0] EXP_DONE  = 10'b1000_00_0_000;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // ---------------- driver ----------------
    // Entered just after a rising edge; runs one op on instance u and returns
    // just after the rising edge of the following IDLE cycle. Bit c of poke
    // raises start during cycle c (c >= 1) to confirm it is ignored.
    task automatic run_op(input int u, input logic [31:0] av, input logic [31:0] bv,
                          input logic [15:0] poke);
        int n;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            if (u == 0 || (((av >> (8 * (k % 4))) & 32'hFF) != 0 &&
                           ((bv >> (16 * (k / 4))) & 32'hFFFF) != 0))
                exp_q.push_back(3'(k));
        end
        n = exp_q.size();
        a_v[u]     = av;
        b_v[u]     = bv;
        start_v[u] = 1'b1;
        @(negedge clk);
        chk($sformatf("u%0d a=%0h b=%0h c0 accept", u, av, bv), 64'(obs(u)), 64'(EXP_CLR));
        for (int c = 1; c <= n + 1; c++) begin
            @(posedge clk);
            #1;
            start_v[u] = poke[c];
            @(negedge clk);
            if (c <= n)
                chk($sformatf("u%0d a=%0h b=%0h c%0d run", u, av, bv, c),
                    64'(obs(u)), 64'(exp_run(int'(exp_q.pop_front()))));
            else begin
                chk($sformatf("u%0d a=%0h b=%0h c%0d done", u, av, bv, c), 64'(obs(u)), 64'(EXP_DONE));
                chk($sformatf("u%0d a=%0h b=%0h product", u, av, bv), prod[u], 64'(av) * 64'(bv));
            end
        end
        @(posedge clk);
        #1;
        start_v[u] = 1'b0;
    endtask

    task automatic idle_cycle(input int u);
        start_v[u] = 1'b0;
        @(negedge clk);
        chk($sformatf("u%0d idle", u), 64'(obs(u)), 64'(EXP_IDLE));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sparse_word();
        logic [31:0] w;
        w = $urandom;
        for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 1) == 0) w[8*i +: 8] = 8'd0;
        return w;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        for (int u = 0; u < 2; u++) begin
            start_v[u] = 1'b0;
            a_v[u]     = '0;
            b_v[u]     = '0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("u0 reset outputs", 64'(obs(0)), 64'(EXP_IDLE));
        chk("u1 reset outputs", 64'(obs(1)), 64'(EXP_IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0);
        idle_cycle(0);
        run_op(1, 32'd3, 32'd5, 16'h0);
        idle_cycle(1);
        run_op(1, 32'd0, 32'h1234, 16'h0);
        idle_cycle(1);
        run_op(1, 32'h0100_0000, 32'h0001_0000, 16'h0);
        idle_cycle(1);

        // start pulses at cycles 3 and 9 ignored; back-to-back start at cycle 10
        run_op(0, 32'h89AB_CDEF, 32'h1357_9BDF, 16'h0208);
        run_op(0, 32'h0000_0102, 32'h0304_0000, 16'h0);
        idle_cycle(0);

        // Reset mid-operation at cycle 4
        a_v[0]     = 32'hDEAD_BEEF;
        b_v[0]     = 32'hCAFE_F00D;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("u0 reset mid-op outputs", 64'(obs(0)), 64'(EXP_IDLE));
        chk("u0 reset mid-op state", 64'(u0.state), 64'(IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_op(0, 32'd7, 32'd6, 16'h0);
        idle_cycle(0);

        // Randomized operands, sparse bytes to exercise skipping
        for (int i = 0; i < 12; i++) begin
            run_op(1, sparse_word(), sparse_word(), 16'h0);
            if ($urandom_range(0, 1) == 1) idle_cycle(1);
        end
        for (int i = 0; i < 4; i++)
            run_op(0, sparse_word(), $urandom, 16'h0);
        idle_cycle(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
